// File: rtl/usb_rx_deserializer_pkg.sv
// USB receive path shared types.
// Line states, FSM states and the line decoder.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    J, K, SE0, SE1
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE, SYNC, DATA, EOP, WAIT
  } rx_state_t;

  function automatic line_state_t decode_line(
    input logic dp,
    input logic dm
  );
    unique case ({dp, dm})
      2'b10:   return J;
      2'b01:   return K;
      2'b00:   return SE0;
      default: return SE1;
    endcase
  endfunction

endpackage

// File: rtl/usb_rx_deserializer_if.sv
// Line inputs and decoded byte stream
// of the USB receive deserializer.
interface usb_rx_deserializer_if;

  logic       d_plus_in;
  logic       d_minus_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_eop;
  logic       rx_error;

  modport master (
    input  d_plus_in, d_minus_in,
    output rx_data, rx_valid,
    output rx_active, rx_eop, rx_error
  );

  modport slave (
    output d_plus_in, d_minus_in,
    input  rx_data, rx_valid,
    input  rx_active, rx_eop, rx_error
  );

endinterface

// File: rtl/usb_rx_deserializer_bit_recovery.sv
// Line synchroniser, line-state decode and
// edge-aligned sample strobe generation.
module usb_rx_bit_recovery
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        d_plus_in,
  input  logic        d_minus_in,
  output line_state_t lstate,
  output logic        strobe
);

  localparam int PW = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0] HALF =
    PW'(OVERSAMPLE / 2);
  localparam logic [PW-1:0] LAST =
    PW'(OVERSAMPLE - 1);

  logic [1:0]    dp_s;
  logic [1:0]    dm_s;
  line_state_t   lstate_q;
  logic [PW-1:0] phase;
  logic [PW-1:0] cnt;

  assign lstate = decode_line(dp_s[1], dm_s[1]);

  // An edge restarts the bit window in the same cycle.
  assign cnt    = (lstate != lstate_q) ? '0 : phase;
  assign strobe = (cnt == HALF);

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      dp_s     <= 2'b11;
      dm_s     <= 2'b00;
      lstate_q <= J;
      phase    <= '0;
    end else begin
      dp_s     <= {dp_s[0], d_plus_in};
      dm_s     <= {dm_s[0], d_minus_in};
      lstate_q <= lstate;
      phase    <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx_deserializer.sv
// Oversampled USB receiver: NRZI decode, SYNC,
// unstuffing, LSB-first byte assembly and EOP.
module usb_rx_deserializer
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 4,
  parameter int SYNC_BITS  = 8,
  parameter int MAX_ONES   = 6
) (
  input logic                  clk,
  input logic                  RST,
  usb_rx_deserializer_if.master bus
);

  localparam int ZW = $clog2(SYNC_BITS + 1);
  localparam int OW = $clog2(MAX_ONES + 1);
  localparam logic [ZW-1:0] Z_END = ZW'(SYNC_BITS - 1);
  localparam logic [ZW-1:0] Z_MAX = ZW'(SYNC_BITS);
  localparam logic [OW-1:0] O_MAX = OW'(MAX_ONES);

  line_state_t lstate;
  logic        strobe;

  usb_rx_bit_recovery #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_rec (
    .clk       (clk),
    .RST       (RST),
    .d_plus_in (bus.d_plus_in),
    .d_minus_in(bus.d_minus_in),
    .lstate    (lstate),
    .strobe    (strobe)
  );

  rx_state_t     state;
  line_state_t   prev;
  logic [ZW-1:0] zcnt;
  logic [OW-1:0] ones;
  logic [2:0]    bcnt;
  logic [2:0]    jcnt;
  logic          se0_seen;
  logic [7:0]    sreg;
  logic [7:0]    data;
  logic          valid;
  logic          active;
  logic          eop;
  logic          err;
  logic          nrzi;
  logic          is_jk;
  logic [7:0]    shifted;

  assign nrzi    = (lstate == prev);
  assign is_jk   = (lstate == J) || (lstate == K);
  assign shifted = {nrzi, sreg[7:1]};

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      prev     <= J;
      zcnt     <= '0;
      ones     <= '0;
      bcnt     <= '0;
      jcnt     <= '0;
      se0_seen <= 1'b0;
      sreg     <= '0;
      data     <= '0;
      valid    <= 1'b0;
      active   <= 1'b0;
      eop      <= 1'b0;
      err      <= 1'b0;
    end else begin
      valid <= 1'b0;
      eop   <= 1'b0;
      err   <= 1'b0;
      if (strobe) begin
        prev <= lstate;
        unique case (state)
          IDLE: begin
            jcnt     <= '0;
            se0_seen <= 1'b0;
            if (lstate == K) begin
              state <= SYNC;
              zcnt  <= ZW'(1);
            end
          end
          SYNC: begin
            if (!is_jk) begin
              err   <= 1'b1;
              state <= WAIT;
            end else if (!nrzi) begin
              if (zcnt != Z_MAX)
                zcnt <= zcnt + 1'b1;
            end else if (zcnt == Z_END) begin
              state  <= DATA;
              active <= 1'b1;
              ones   <= '0;
              bcnt   <= '0;
            end else begin
              err   <= 1'b1;
              state <= WAIT;
            end
          end
          DATA: begin
            if (lstate == SE0) begin
              state <= EOP;
            end else if (lstate == SE1 ||
                         (nrzi && ones == O_MAX)) begin
              err    <= 1'b1;
              active <= 1'b0;
              state  <= WAIT;
            end else if (ones == O_MAX) begin
              ones <= '0;
            end else begin
              sreg <= shifted;
              bcnt <= bcnt + 1'b1;
              ones <= nrzi ? ones + 1'b1 : '0;
              if (bcnt == 3'd7) begin
                data  <= shifted;
                valid <= 1'b1;
              end
            end
          end
          EOP: begin
            if (lstate == J) begin
              eop    <= 1'b1;
              err    <= (bcnt != 3'd0);
              active <= 1'b0;
              state  <= IDLE;
            end else if (lstate != SE0) begin
              err    <= 1'b1;
              active <= 1'b0;
              state  <= WAIT;
            end
          end
          WAIT: begin
            if (lstate == SE0) begin
              se0_seen <= 1'b1;
              jcnt     <= '0;
            end else if (lstate == J) begin
              if (se0_seen || jcnt == 3'd7)
                state <= IDLE;
              else
                jcnt <= jcnt + 1'b1;
            end else begin
              se0_seen <= 1'b0;
              jcnt     <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.rx_data   = data;
  assign bus.rx_valid  = valid;
  assign bus.rx_active = active;
  assign bus.rx_eop    = eop;
  assign bus.rx_error  = err;

endmodule

// File: tb/tb_usb_rx_deserializer.sv
// Scoreboard bench: NRZI/stuffing encoder drives
// the line, expected bytes are queued and popped.
module tb_usb_rx_deserializer;
  import usb_rx_pkg::*;

  logic clk = 1'b0;
  logic RST;
  logic dp, dm;
  logic sel8;

  always #5 clk = ~clk;

  usb_rx_deserializer_if if4();
  usb_rx_deserializer_if if8();

  assign if4.d_plus_in  = dp;
  assign if4.d_minus_in = dm;
  assign if8.d_plus_in  = dp;
  assign if8.d_minus_in = dm;

  usb_rx_deserializer #(.OVERSAMPLE(4)) dut4 (
    .clk(clk),
    .RST(RST),
    .bus(if4.master)
  );

  usb_rx_deserializer #(.OVERSAMPLE(8)) dut8 (
    .clk(clk),
    .RST(RST),
    .bus(if8.master)
  );

  logic [7:0] m_data;
  logic m_valid, m_active, m_eop, m_error;

  assign m_data   = sel8 ? if8.rx_data   : if4.rx_data;
  assign m_valid  = sel8 ? if8.rx_valid  : if4.rx_valid;
  assign m_active = sel8 ? if8.rx_active : if4.rx_active;
  assign m_eop    = sel8 ? if8.rx_eop    : if4.rx_eop;
  assign m_error  = sel8 ? if8.rx_error  : if4.rx_error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_eop, n_err, n_eop_err;
  logic [7:0] exp_q[$];

  int   os, jit, e_prev, ones;
  logic lvl;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!RST) begin
      if (m_valid) begin
        chk("active_at_valid", 32'(m_active), 1);
        if (exp_q.size() == 0)
          chk("extra_byte", 32'(m_valid), 0);
        else
          chk("rx_data", 32'(m_data), 32'(exp_q.pop_front()));
      end
      if (m_eop) begin
        n_eop++;
        chk("eop_vs_valid", 32'(m_valid), 0);
      end
      if (m_error) n_err++;
      if (m_eop && m_error) n_eop_err++;
    end
  end

  task automatic drive(input logic p, input logic m,
                       input int n);
    dp = p;
    dm = m;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    int e_next, dur;
    if (!b) lvl = ~lvl;
    e_next = (jit != 0) ?
      int'($urandom_range(2)) - 1 : 0;
    dur    = os + e_next - e_prev;
    e_prev = e_next;
    drive(lvl, ~lvl, dur);
  endtask

  task automatic tx_sync();
    lvl    = 1'b1;
    e_prev = 0;
    ones   = 0;
    repeat (7) send_bit(1'b0);
    send_bit(1'b1);
  endtask

  task automatic tx_bits(input logic [31:0] v,
                         input int n, input bit stuff);
    for (int i = 0; i < n; i++) begin
      send_bit(v[i]);
      ones = v[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        send_bit(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic tx_byte(input logic [7:0] b);
    exp_q.push_back(b);
    tx_bits(32'(b), 8, 1'b1);
  endtask

  task automatic tx_eop();
    drive(1'b0, 1'b0, 2 * os);
    drive(1'b1, 1'b0, 12 * os);
    lvl    = 1'b1;
    e_prev = 0;
  endtask

  task automatic begin_test();
    n_eop     = 0;
    n_err     = 0;
    n_eop_err = 0;
    exp_q.delete();
  endtask

  task automatic end_test(input string t, input int eop,
                          input int err, input int both);
    chk({t, "_eop"},    32'(n_eop), 32'(eop));
    chk({t, "_err"},    32'(n_err), 32'(err));
    chk({t, "_eop_err"}, 32'(n_eop_err), 32'(both));
    chk({t, "_missing"}, 32'(exp_q.size()), 0);
    chk({t, "_active_end"}, 32'(m_active), 0);
  endtask

  initial begin
    sel8 = 1'b0;
    os   = 4;
    jit  = 0;
    lvl  = 1'b1;
    dp   = 1'b1;
    dm   = 1'b0;
    RST  = 1'b1;
    begin_test();
    repeat (3) @(negedge clk);
    chk("rst_out", 32'({m_data, m_valid, m_active,
                        m_eop, m_error}), 0);
    RST = 1'b0;
    drive(1'b1, 1'b0, 20);

    begin_test();
    tx_sync();
    tx_byte(8'hA5);
    chk("t1_active", 32'(m_active), 1);
    tx_eop();
    end_test("t1", 1, 0, 0);

    begin_test();
    tx_sync();
    tx_byte(8'hFF);
    tx_byte(8'hFF);
    tx_eop();
    end_test("t2", 1, 0, 0);

    begin_test();
    tx_sync();
    tx_bits(32'h7F, 7, 1'b0);
    tx_eop();
    end_test("t3", 0, 1, 0);

    begin_test();
    tx_sync();
    tx_byte(8'h3C);
    tx_eop();
    end_test("t3b", 1, 0, 0);

    begin_test();
    tx_sync();
    tx_byte(8'h5A);
    tx_bits(32'h3, 4, 1'b1);
    tx_eop();
    end_test("t4", 1, 1, 1);

    begin_test();
    tx_sync();
    tx_bits(32'h6, 4, 1'b1);
    chk("t5_active_pre", 32'(m_active), 1);
    RST = 1'b1;
    #1;
    chk("t5_rst_out", 32'({m_data, m_valid, m_active,
                           m_eop, m_error}), 0);
    drive(1'b1, 1'b0, 5);
    RST = 1'b0;
    drive(1'b1, 1'b0, 20);
    begin_test();
    tx_sync();
    tx_byte(8'h11);
    tx_eop();
    end_test("t5", 1, 0, 0);

    RST  = 1'b1;
    sel8 = 1'b1;
    os   = 8;
    jit  = 1;
    drive(1'b1, 1'b0, 4);
    RST = 1'b0;
    drive(1'b1, 1'b0, 40);
    begin_test();
    tx_sync();
    tx_byte(8'h00);
    tx_byte(8'h80);
    tx_byte(8'h7E);
    tx_eop();
    end_test("t6", 1, 0, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_rx_deserializer.md
Name: usb_rx_deserializer

Overview:
Parametrised successor to the receive path of usb_transceiver. It turns the raw differential line (d_plus_in/d_minus_in), sampled with a clock OVERSAMPLE times faster than the bit rate, into decoded bytes. Stages: input synchroniser, bit-clock recovery, NRZI decode, SYNC detect, bit-unstuffing, LSB-first byte assembly, EOP detect. Sits between the line pads and the packet layer, replacing the fixed 1-clock-per-bit receiver.

Parameters:
OVERSAMPLE, 4, clocks per USB bit time; legal range 3..16.
SYNC_BITS, 8, decoded SYNC length: (SYNC_BITS-1) zeros then a one. Use 8 for FS/LS, 32 for HS-style testing.
MAX_ONES, 6, consecutive decoded ones after which a stuffed zero is mandatory.

Ports:
clk  in  1  system clock, OVERSAMPLE x bit rate
RST  in  1  reset; asynchronous, active-high
d_plus_in  in  1  raw D+ line, asynchronous to clk
d_minus_in  in  1  raw D- line, asynchronous to clk
rx_data  out  8  received byte, LSB = first bit on wire; valid only while rx_valid=1
rx_valid  out  1  one-cycle strobe, rx_data holds a new byte
rx_active  out  1  high from the end of SYNC to EOP or error
rx_eop  out  1  one-cycle strobe at end of packet
rx_error  out  1  one-cycle strobe: stuff, SYNC, SE1 or alignment error

Behaviour:
- Reset: all outputs 0, state IDLE, previous line state J, phase counter 0, ones counter 0, bit counter 0.
- Input sync: 2-flop synchroniser on both lines. Decode line state: J=(1,0), K=(0,1), SE0=(0,0), SE1=(1,1).
- Bit recovery:
  - Phase counter counts 0..OVERSAMPLE-1 and wraps.
  - Any change of the synchronised line state forces the counter to 0.
  - Sample strobe fires when counter == OVERSAMPLE/2 (integer division). This tolerates ±1 clock of jitter per edge when OVERSAMPLE ≥ 4.
- NRZI decode: on each strobe, bit = 1 if sampled state equals the previous sampled state, else 0. The previous state updates on every strobe.
- State machine:
  - IDLE: on a strobe with sampled K, go to SYNC, zero counter = 1.
  - SYNC: on decoded 0, increment the zero count.
    - Decoded 1 with zero count == SYNC_BITS-1: go to DATA, rx_active=1, clear ones/bit counters.
    - Decoded 1 with any other zero count, or SE0/SE1 sampled: rx_error pulse, go to WAIT.
  - DATA:
    - Decoded 1: increment the ones counter; shift the bit in.
    - Decoded 0 when ones counter == MAX_ONES: stuffed bit. Discard it and clear the counter.
    - Other decoded 0: shift the bit in, clear the ones counter.
    - Decoded 1 when ones counter == MAX_ONES: stuff error; rx_error pulse, rx_active=0, go to WAIT.
    - SE0 sampled: go to EOP. SE1 sampled: error, go to WAIT.
  - EOP: SE0 strobes accepted. First J strobe: rx_eop pulse, rx_active=0, go to IDLE. If the bit counter mod 8 ≠ 0, rx_error pulses in the same cycle as rx_eop. K or SE1: rx_error pulse, go to WAIT.
  - WAIT: return to IDLE after one SE0 strobe followed by a J strobe, or after 8 consecutive J strobes.
- Byte output: the 8th data bit is shifted in on a strobe. On the next clk, rx_data is loaded and rx_valid=1 for exactly one cycle. rx_data then holds until the next byte.
- Simultaneous events: a byte completed by the last bit before SE0 still produces rx_valid. rx_eop follows it at least OVERSAMPLE cycles later and never coincides with it.
- Latency: line edge to strobe = 2 (synchroniser) + OVERSAMPLE/2 clocks; strobe to rx_valid = 1 clock.
- Reset mid-packet: immediate return to the reset state. No rx_eop or rx_error is generated.
- Wrap: the bit counter is 3 bits and wraps mod 8. Packet length is unbounded.

Decomposition:
- Package usb_rx_pkg:
  - line_state_t enum {J, K, SE0, SE1}
  - rx_state_t enum {IDLE, SYNC, DATA, EOP, WAIT}
  - function decode_line(dp, dm)
- Sub-module usb_rx_bit_recovery: synchroniser, line decode, phase counter. Outputs the line_state_t and the sample strobe. The FSM, unstuffing and byte assembly stay in the top module.

Test Plan:
- OVERSAMPLE=4: SYNC + 0xA5 + EOP (2×SE0, J) -> one rx_valid with rx_data=0xA5, then rx_eop=1, rx_error=0, rx_active high between SYNC end and EOP.
- 0xFF,0xFF with a stuffed 0 inserted after the 6th one -> two rx_valid strobes with 0xFF, no rx_error; stuffed bit absent from data.
- 7 consecutive decoded ones in DATA -> rx_error pulse, rx_active=0, no rx_eop; next valid packet (0x3C) received correctly.
- EOP after 12 data bits (0x5A + 4 bits) -> rx_valid once (0x5A), then rx_eop and rx_error in the same cycle.
- OVERSAMPLE=8, edges jittered ±1 clock, SYNC + 0x00,0x80,0x7E -> all three bytes correct, no error.
- RST asserted mid-byte -> outputs 0 immediately; after release, SYNC + 0x11 + EOP -> rx_data=0x11 with no spurious strobes.
